fft_frame_scheduler: RTL and testbench

Sequences the 512-point FFT core's input and config streams from the microphone sample stream. After reset it sends one FFT configuration word, then cuts the 48 kHz-class sample stream into FRAME_LEN-sample frames with a correct tlast. It applies configuration changes only between frames, counts completed output frames, and flags input overruns. It sits between the microphone block and the FFT core and replaces the free-running sample counter.

---
 rtl/fft_sched_pkg.sv | 22 ++
 rtl/fft_frame_scheduler.sv | 162 ++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_sched_pkg.sv
// rtl/fft_sched_pkg.sv - shared types and constants for the FFT frame scheduler
package fft_sched_pkg;

   typedef enum logic [1:0] {
      ST_CFG    = 2'd0,
      ST_IDLE   = 2'd1,
      ST_STREAM = 2'd2
   } sched_state_t;

   localparam int FRAME_LEN_DEF = 512;
   localparam int SAMPLE_W_DEF  = 16;

   // FFT config word fields: bit 0 selects forward transform, [10:1] is the scale schedule
   localparam int CFG_FWD_BIT   = 0;
   localparam int CFG_SCALE_LSB = 1;
   localparam int CFG_SCALE_MSB = 10;

   function automatic logic [15:0] fft_cfg_word(input logic fwd, input logic [9:0] scale);
      return {5'b0, scale, fwd};
   endfunction

endpackage

// File: rtl/fft_frame_scheduler.sv
// rtl/fft_frame_scheduler.sv - frames the mic sample stream and config words for the FFT core
module fft_frame_scheduler
   import fft_sched_pkg::*;
#(
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int SAMPLE_W  = SAMPLE_W_DEF,
   parameter int CFG_W     = 16,
   parameter int CNT_W     = 16
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  enable_in,
   input  logic [SAMPLE_W-1:0]   sample_in,
   input  logic                  sample_valid_in,
   input  logic [CFG_W-1:0]      config_in,
   input  logic                  config_update_in,
   output logic [2*SAMPLE_W-1:0] s_data_tdata_out,
   output logic                  s_data_tvalid_out,
   output logic                  s_data_tlast_out,
   input  logic                  s_data_tready_in,
   output logic [CFG_W-1:0]      s_config_tdata_out,
   output logic                  s_config_tvalid_out,
   input  logic                  s_config_tready_in,
   input  logic                  m_data_tvalid_in,
   input  logic                  m_data_tready_in,
   input  logic                  m_data_tlast_in,
   output logic                  frame_done_out,
   output logic [CNT_W-1:0]      frame_count_out,
   output logic [CNT_W-1:0]      drop_count_out,
   output logic                  overrun_out,
   output logic                  busy_out
);

   localparam int               IDX_W    = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   sched_state_t        r_state;
   logic                r_first;
   logic                r_pend;
   logic [CFG_W-1:0]    r_pend_word;
   logic [CFG_W-1:0]    r_cfg_tdata;
   logic                r_cfg_tvalid;
   logic [SAMPLE_W-1:0] r_sample;
   logic                r_dv;
   logic                r_tlast;
   logic [IDX_W-1:0]    r_idx;
   logic [CNT_W-1:0]    r_frame_cnt;
   logic [CNT_W-1:0]    r_drop_cnt;
   logic                r_overrun;
   logic                r_done;

   logic             w_data_hs;
   logic             w_out_hs;
   logic             w_pend_set;
   logic             w_pend_any;
   logic [CFG_W-1:0] w_pend_word;

   assign w_data_hs   = r_dv && s_data_tready_in;
   assign w_out_hs    = m_data_tvalid_in && m_data_tready_in && m_data_tlast_in;
   // The first clock after reset captures config_in as if an update had been strobed
   assign w_pend_set  = config_update_in || r_first;
   assign w_pend_any  = w_pend_set || r_pend;
   assign w_pend_word = w_pend_set ? config_in : r_pend_word;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state      <= ST_CFG;
         r_first      <= 1'b1;
         r_pend       <= 1'b0;
         r_pend_word  <= '0;
         r_cfg_tdata  <= '0;
         r_cfg_tvalid <= 1'b0;
         r_sample     <= '0;
         r_dv         <= 1'b0;
         r_tlast      <= 1'b0;
         r_idx        <= '0;
         r_frame_cnt  <= '0;
         r_drop_cnt   <= '0;
         r_overrun    <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_first <= 1'b0;
         r_done  <= w_out_hs;
         if (w_out_hs) begin
            r_frame_cnt <= r_frame_cnt + CNT_ONE;
         end
         if (w_pend_set) begin
            r_pend_word <= config_in;
            r_pend      <= 1'b1;
         end

         case (r_state)
            ST_CFG: begin
               if (!r_cfg_tvalid) begin
                  r_cfg_tdata  <= w_pend_word;
                  r_cfg_tvalid <= 1'b1;
                  r_pend       <= 1'b0;
               end else if (s_config_tready_in) begin
                  r_cfg_tvalid <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end

            ST_IDLE: begin
               if (r_pend) begin
                  r_state <= ST_CFG;
               end else if (enable_in && sample_valid_in) begin
                  r_sample <= sample_in;
                  r_dv     <= 1'b1;
                  r_tlast  <= 1'b0;
                  r_idx    <= IDX_ONE;
                  r_state  <= ST_STREAM;
               end
            end

            ST_STREAM: begin
               if (w_data_hs && r_tlast) begin
                  // A strobe colliding with the final handshake may open the next frame directly
                  if (sample_valid_in && enable_in && !w_pend_any) begin
                     r_sample <= sample_in;
                     r_dv     <= 1'b1;
                     r_tlast  <= 1'b0;
                     r_idx    <= IDX_ONE;
                  end else begin
                     r_dv    <= 1'b0;
                     r_tlast <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end else if (sample_valid_in && (!r_dv || w_data_hs)) begin
                  r_sample <= sample_in;
                  r_dv     <= 1'b1;
                  r_tlast  <= (r_idx == LAST_IDX);
                  r_idx    <= r_idx + IDX_ONE;
               end else if (sample_valid_in) begin
                  if (r_drop_cnt != '1) begin
                     r_drop_cnt <= r_drop_cnt + CNT_ONE;
                  end
                  r_overrun <= 1'b1;
               end else if (w_data_hs) begin
                  r_dv <= 1'b0;
               end
            end

            default: r_state <= ST_CFG;
         endcase
      end
   end

   assign s_data_tdata_out    = {r_sample, {SAMPLE_W{1'b0}}};
   assign s_data_tvalid_out   = r_dv;
   assign s_data_tlast_out    = r_tlast;
   assign s_config_tdata_out  = r_cfg_tdata;
   assign s_config_tvalid_out = r_cfg_tvalid;
   assign frame_done_out      = r_done;
   assign frame_count_out     = r_frame_cnt;
   assign drop_count_out      = r_drop_cnt;
   assign overrun_out         = r_overrun;
   assign busy_out            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb/tb_fft_frame_scheduler.sv - self-checking bench for fft_frame_scheduler
module tb_fft_frame_scheduler;
   import fft_sched_pkg::*;

   localparam int FL = 512;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        enable_in;
   logic [15:0] sample_in;
   logic        sample_valid_in;
   logic [15:0] config_in;
   logic        config_update_in;
   logic [31:0] s_data_tdata_out;
   logic        s_data_tvalid_out;
   logic        s_data_tlast_out;
   logic        s_data_tready_in;
   logic [15:0] s_config_tdata_out;
   logic        s_config_tvalid_out;
   logic        s_config_tready_in;
   logic        m_data_tvalid_in;
   logic        m_data_tready_in;
   logic        m_data_tlast_in;
   logic        frame_done_out;
   logic [15:0] frame_count_out;
   logic [15:0] drop_count_out;
   logic        overrun_out;
   logic        busy_out;

   int total = 0;
   int bad   = 0;

   fft_frame_scheduler #(.FRAME_LEN(FL), .SAMPLE_W(16), .CFG_W(16), .CNT_W(16)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
      .sample_in(sample_in), .sample_valid_in(sample_valid_in),
      .config_in(config_in), .config_update_in(config_update_in),
      .s_data_tdata_out(s_data_tdata_out), .s_data_tvalid_out(s_data_tvalid_out),
      .s_data_tlast_out(s_data_tlast_out), .s_data_tready_in(s_data_tready_in),
      .s_config_tdata_out(s_config_tdata_out), .s_config_tvalid_out(s_config_tvalid_out),
      .s_config_tready_in(s_config_tready_in),
      .m_data_tvalid_in(m_data_tvalid_in), .m_data_tready_in(m_data_tready_in),
      .m_data_tlast_in(m_data_tlast_in),
      .frame_done_out(frame_done_out), .frame_count_out(frame_count_out),
      .drop_count_out(drop_count_out), .overrun_out(overrun_out), .busy_out(busy_out)
   );

   always #5 clk_in = ~clk_in;

   // Observed traffic, captured mid-cycle so handshakes are seen before the edge that completes them
   int          cyc = 0;
   logic [32:0] got_q[$];
   int          got_cyc[$];
   logic [15:0] cfg_q[$];
   int          cfg_cyc[$];
   int          tv_cnt = 0;
   int          done_hi = 0;
   int          done_rise = 0;
   logic        done_prev = 1'b0;

   always @(posedge clk_in) cyc <= cyc + 1;

   always @(negedge clk_in) begin
      if (rst_in) begin
         if (s_data_tvalid_out) tv_cnt++;
         if (s_data_tvalid_out && s_data_tready_in) begin
            got_q.push_back({s_data_tdata_out, s_data_tlast_out});
            got_cyc.push_back(cyc);
         end
         if (s_config_tvalid_out && s_config_tready_in) begin
            cfg_q.push_back(s_config_tdata_out);
            cfg_cyc.push_back(cyc);
         end
         if (frame_done_out) begin
            done_hi++;
            if (!done_prev) done_rise++;
         end
      end
      done_prev = frame_done_out;
   end

   // Reference model: a strobe joins the stream if a frame is open or enable is high,
   // and every FL-th accepted sample carries tlast.
   logic [32:0] exp_q[$];
   int          mk = 0;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic strobe(input logic [15:0] v, input bit drop, input int gap);
      if (!drop && (mk != 0 || enable_in)) begin
         exp_q.push_back({v, 16'h0000, (mk == FL - 1)});
         mk = (mk + 1) % FL;
      end
      sample_in       = v;
      sample_valid_in = 1'b1;
      tick();
      sample_valid_in  = 1'b0;
      config_update_in = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic clear_q();
      got_q.delete();
      got_cyc.delete();
      exp_q.delete();
      cfg_q.delete();
      cfg_cyc.delete();
   endtask

   function automatic int first_diff();
      if (got_q.size() != exp_q.size()) return -2;
      foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   function automatic int count_tlast();
      int n = 0;
      foreach (got_q[i]) if (got_q[i][0]) n++;
      return n;
   endfunction

   task automatic test_reset();
      int n;
      int hold;
      rst_in = 1'b0; enable_in = 1'b0; sample_in = '0; sample_valid_in = 1'b0;
      config_in = fft_cfg_word(1'b1, 10'd0); config_update_in = 1'b0;
      s_data_tready_in = 1'b0; s_config_tready_in = 1'b0;
      m_data_tvalid_in = 1'b0; m_data_tready_in = 1'b0; m_data_tlast_in = 1'b0;
      repeat (3) tick();
      total++;
      if ({s_data_tvalid_out, s_data_tlast_out, s_config_tvalid_out, frame_done_out, overrun_out} !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b required 00000",
                  {s_data_tvalid_out, s_data_tlast_out, s_config_tvalid_out, frame_done_out, overrun_out});
      end
      total++;
      if (s_data_tdata_out !== 32'h0 || s_config_tdata_out !== 16'h0) begin
         bad++;
         $display("FAIL reset_data: got %h/%h required 0/0", s_data_tdata_out, s_config_tdata_out);
      end
      total++;
      if (frame_count_out !== 16'h0 || drop_count_out !== 16'h0 || busy_out !== 1'b1) begin
         bad++;
         $display("FAIL reset_counters: got frames=%0d drops=%0d busy=%b required 0 0 1",
                  frame_count_out, drop_count_out, busy_out);
      end
      rst_in = 1'b1;
      n = 0;
      while (!s_config_tvalid_out && n < 10) begin
         tick();
         n++;
      end
      total++;
      if (n != 1) begin
         bad++;
         $display("FAIL cfg_first_latency: got %0d cycles required 1", n);
      end
      config_in = 16'hBEEF;
      hold = 0;
      repeat (5) begin
         if (s_config_tvalid_out && s_config_tdata_out == 16'h0001) hold++;
         tick();
      end
      total++;
      if (hold != 5 || cfg_q.size() != 0) begin
         bad++;
         $display("FAIL cfg_hold: got held=%0d handshakes=%0d required 5 0", hold, cfg_q.size());
      end
      s_config_tready_in = 1'b1;
      tick();
      total++;
      if (cfg_q.size() != 1 || busy_out !== 1'b0 || s_config_tvalid_out !== 1'b0) begin
         bad++;
         $display("FAIL cfg_handshake: got count=%0d busy=%b tvalid=%b required 1 0 0",
                  cfg_q.size(), busy_out, s_config_tvalid_out);
      end else begin
         total++;
         if (cfg_q[0] !== 16'h0001) begin
            bad++;
            $display("FAIL cfg_word: got %h required 0001", cfg_q[0]);
         end
      end
      s_data_tready_in = 1'b1;
      clear_q();
   endtask

   task automatic test_stream();
      int r;
      enable_in = 1'b1;
      for (int j = 0; j < 2 * FL; j++) strobe(16'($urandom), 1'b0, $urandom_range(1, 2));
      repeat (6) tick();
      r = first_diff();
      total++;
      if (r != -1) begin
         bad++;
         $display("FAIL stream_data: first bad entry %0d got size %0d required size %0d", r, got_q.size(), exp_q.size());
      end
      total++;
      if (count_tlast() != 2 || busy_out !== 1'b0) begin
         bad++;
         $display("FAIL stream_tlast: got tlasts=%0d busy=%b required 2 0", count_tlast(), busy_out);
      end
      clear_q();
   endtask

   task automatic test_back_to_back();
      int r;
      enable_in = 1'b1;
      for (int j = 0; j < 2 * FL; j++) strobe(16'($urandom), 1'b0, 0);
      repeat (6) tick();
      r = first_diff();
      total++;
      if (r != -1) begin
         bad++;
         $display("FAIL b2b_data: first bad entry %0d got size %0d required size %0d", r, got_q.size(), exp_q.size());
      end
      total++;
      if (drop_count_out !== 16'h0 || overrun_out !== 1'b0) begin
         bad++;
         $display("FAIL b2b_nodrop: got drops=%0d overrun=%b required 0 0", drop_count_out, overrun_out);
      end
      clear_q();
   endtask

   task automatic test_overrun();
      int r;
      enable_in = 1'b1;
      for (int j = 0; j < FL + 2; j++) begin
         if (j == 200) s_data_tready_in = 1'b0;
         if (j == 203) s_data_tready_in = 1'b1;
         strobe(16'($urandom), (j == 201 || j == 202), 1);
      end
      repeat (6) tick();
      r = first_diff();
      total++;
      if (r != -1) begin
         bad++;
         $display("FAIL overrun_data: first bad entry %0d got size %0d required size %0d", r, got_q.size(), exp_q.size());
      end
      total++;
      if (drop_count_out !== 16'd2 || overrun_out !== 1'b1) begin
         bad++;
         $display("FAIL overrun_count: got drops=%0d overrun=%b required 2 1", drop_count_out, overrun_out);
      end
      total++;
      if (count_tlast() != 1 || got_q.size() != FL) begin
         bad++;
         $display("FAIL overrun_frame: got tlasts=%0d size=%0d required 1 %0d", count_tlast(), got_q.size(), FL);
      end
      clear_q();
   endtask

   task automatic test_config_mid_frame();
      int r;
      enable_in = 1'b1;
      for (int j = 0; j < FL; j++) begin
         if (j == 100) begin
            config_in        = fft_cfg_word(1'b1, 10'd1);
            config_update_in = 1'b1;
         end
         strobe(16'($urandom), 1'b0, 1);
      end
      repeat (10) tick();
      total++;
      if (cfg_q.size() != 1 || got_q.size() != FL) begin
         bad++;
         $display("FAIL cfg_mid_count: got cfg=%0d data=%0d required 1 %0d", cfg_q.size(), got_q.size(), FL);
      end else begin
         total++;
         if (cfg_q[0] !== 16'h0003 || cfg_cyc[0] <= got_cyc[FL-1]) begin
            bad++;
            $display("FAIL cfg_mid_order: got word=%h cfg_cyc=%0d tlast_cyc=%0d required 0003 after tlast",
                     cfg_q[0], cfg_cyc[0], got_cyc[FL-1]);
         end
      end
      for (int j = 0; j < FL; j++) strobe(16'($urandom), 1'b0, 1);
      repeat (6) tick();
      r = first_diff();
      total++;
      if (r != -1) begin
         bad++;
         $display("FAIL cfg_mid_data: first bad entry %0d got size %0d required size %0d", r, got_q.size(), exp_q.size());
      end else begin
         total++;
         if (cfg_q.size() != 1 || got_cyc[FL] <= cfg_cyc[0]) begin
            bad++;
            $display("FAIL cfg_mid_next: got cfg=%0d idx0_cyc=%0d cfg_cyc=%0d required 1 and idx0 after cfg",
                     cfg_q.size(), got_cyc[FL], cfg_cyc[0]);
         end
      end
      clear_q();
   endtask

   task automatic test_enable_drop();
      int r;
      int tv0;
      enable_in = 1'b1;
      for (int j = 0; j < FL; j++) begin
         if (j == 300) enable_in = 1'b0;
         strobe(16'($urandom), 1'b0, 1);
      end
      repeat (3) tick();
      tv0 = tv_cnt;
      for (int j = 0; j < 20; j++) strobe(16'($urandom), 1'b0, 1);
      total++;
      if (tv_cnt != tv0 || got_q.size() != FL) begin
         bad++;
         $display("FAIL enable_idle: got extra tvalid=%0d size=%0d required 0 %0d", tv_cnt - tv0, got_q.size(), FL);
      end
      enable_in = 1'b1;
      for (int j = 0; j < FL; j++) strobe(16'($urandom), 1'b0, 1);
      repeat (6) tick();
      r = first_diff();
      total++;
      if (r != -1 || count_tlast() != 2) begin
         bad++;
         $display("FAIL enable_data: first bad entry %0d tlasts=%0d required -1 2", r, count_tlast());
      end
      clear_q();
   endtask

   task automatic test_frame_done();
      int h0;
      int r0;
      bit ok_pulse;
      bit exp_pulse;
      h0 = done_hi;
      r0 = done_rise;
      ok_pulse = 1'b1;
      for (int e = 0; e < 5; e++) begin
         exp_pulse = (e != 2 && e != 4);
         m_data_tvalid_in = 1'b1;
         m_data_tready_in = (e != 2);
         m_data_tlast_in  = (e != 4);
         tick();
         m_data_tvalid_in = 1'b0;
         m_data_tready_in = 1'b0;
         m_data_tlast_in  = 1'b0;
         if (frame_done_out !== exp_pulse) ok_pulse = 1'b0;
         repeat ($urandom_range(1, 3)) tick();
         if (frame_done_out !== 1'b0) ok_pulse = 1'b0;
      end
      total++;
      if (!ok_pulse) begin
         bad++;
         $display("FAIL done_timing: got pulse pattern wrong required pulse on cycle after each tlast handshake");
      end
      total++;
      if (frame_count_out !== 16'd3 || done_rise - r0 != 3 || done_hi - h0 != 3) begin
         bad++;
         $display("FAIL done_count: got count=%0d pulses=%0d high_cycles=%0d required 3 3 3",
                  frame_count_out, done_rise - r0, done_hi - h0);
      end
   endtask

   task automatic test_async_reset();
      enable_in = 1'b1;
      for (int j = 0; j < 9; j++) strobe(16'($urandom), 1'b0, 1);
      s_data_tready_in = 1'b0;
      strobe(16'($urandom), 1'b0, 1);
      total++;
      if (s_data_tvalid_out !== 1'b1 || busy_out !== 1'b1) begin
         bad++;
         $display("FAIL areset_pre: got tvalid=%b busy=%b required 1 1", s_data_tvalid_out, busy_out);
      end
      #2;
      rst_in = 1'b0;
      #1;
      total++;
      if (s_data_tvalid_out !== 1'b0 || s_data_tdata_out !== 32'h0 || frame_count_out !== 16'h0 ||
          drop_count_out !== 16'h0 || overrun_out !== 1'b0 || busy_out !== 1'b1) begin
         bad++;
         $display("FAIL areset_clear: got tvalid=%b data=%h frames=%0d drops=%0d overrun=%b busy=%b required 0 0 0 0 0 1",
                  s_data_tvalid_out, s_data_tdata_out, frame_count_out, drop_count_out, overrun_out, busy_out);
      end
      tick();
      rst_in = 1'b1;
      mk = 0;
      clear_q();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_stream();
      test_back_to_back();
      test_overrun();
      test_config_mid_frame();
      test_enable_drop();
      test_frame_done();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
